rd53_pix_tot_digitizer: RTL and testbench

Pixel-level digital back end that consumes the asynchronous single-ended discriminator `HIT` of one analogue front end. It synchronises the signal, detects leading and trailing edges, and measures time-over-threshold (ToT) in clock cycles. Each hit's time-of-arrival (BCID) is latched, and a `{TOA, TOT}` word is queued in a small FIFO that a pixel-region reader drains over a valid/ready handshake. It sits between the front-end model and the region readout logic, and its stimulus comes directly from the front end's `HIT` output.

---
 rtl/rd53_pix_tot_digitizer.sv | 156 +++++++++++++++
 tb/tb_rd53_pix_tot_digitizer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd53_pix_tot_digitizer.sv
// Pixel ToT digitiser: synchronises HIT, measures time-over-threshold,
// tags each hit with its BCID and buffers {TOA, TOT} words for readout.
module rd53_pix_tot_digitizer #(
    parameter int TOT_W       = 4,
    parameter int TOA_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HIT,
    input  logic             MASK,
    input  logic [TOA_W-1:0] BCID,
    output logic             HIT_OR,
    output logic [TOT_W-1:0] TOT_DATA,
    output logic [TOA_W-1:0] TOA_DATA,
    output logic             TOT_VALID,
    input  logic             TOT_READY,
    output logic [7:0]       OVF_CNT,
    output logic             BUSY
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = TOA_W + TOT_W;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_PRE = TOT_MAX - 1'b1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SAT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] real_q;
    logic h_s;
    logic h_m;
    logic h_d;
    logic armed;

    state_t state;
    logic [TOT_W-1:0] cnt;
    logic [TOA_W-1:0] toa;
    logic push_q;
    logic [WW-1:0] push_w;

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;
    logic full;
    logic pop;
    logic wr_en;

    assign h_s = sync_q[SYNC_STAGES-1];
    assign h_m = h_s & ~MASK;

    // real_q marks genuine HIT samples, so a level already high out of reset is
    // ignored until a true low has been seen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            real_q <= '0;
            h_d    <= 1'b0;
            armed  <= 1'b0;
            HIT_OR <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], HIT};
            real_q <= {real_q[SYNC_STAGES-2:0], 1'b1};
            h_d    <= h_m;
            HIT_OR <= h_m;
            if (real_q[SYNC_STAGES-1] & ~h_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            toa    <= '0;
            push_q <= 1'b0;
            push_w <= '0;
            BUSY   <= 1'b0;
        end else begin
            push_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (h_m & ~h_d & armed) begin
                        cnt   <= TOT_W'(1);
                        toa   <= BCID;
                        state <= (TOT_W == 1) ? SAT : COUNT;
                        BUSY  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (h_m) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == TOT_PRE)
                            state <= SAT;
                    end else begin
                        push_q <= 1'b1;
                        push_w <= {toa, cnt};
                        state  <= IDLE;
                        BUSY   <= 1'b0;
                    end
                end
                SAT: begin
                    if (!h_m) begin
                        push_q <= 1'b1;
                        push_w <= {toa, TOT_MAX};
                        state  <= IDLE;
                        BUSY   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    assign full      = (count == DEPTH_C);
    assign TOT_VALID = (count != '0);
    assign pop       = TOT_VALID & TOT_READY;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign wr_en     = push_q & (~full | pop);
    assign {TOA_DATA, TOT_DATA} = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            OVF_CNT <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_w;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en & ~pop)
                count <= count + 1'b1;
            else if (~wr_en & pop)
                count <= count - 1'b1;
            if (push_q & ~wr_en & (OVF_CNT != 8'hFF))
                OVF_CNT <= OVF_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_rd53_pix_tot_digitizer.sv
// Bench for rd53_pix_tot_digitizer: directed scenarios plus random traffic
// checked against a pulse-length / queue reference model.
module tb_rd53_pix_tot_digitizer;

    localparam int S    = 2;
    localparam int D    = 2;
    localparam int TMAX = 15;

    logic       CLK = 1'b0;
    logic       RST;
    logic       HIT;
    logic       MASK;
    logic [7:0] BCID;
    logic       HIT_OR;
    logic [3:0] TOT_DATA;
    logic [7:0] TOA_DATA;
    logic       TOT_VALID;
    logic       TOT_READY;
    logic [7:0] OVF_CNT;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    // Reference model state: HIT sample history, current pulse, output queue.
    bit          smp[S];
    bit          smp_real[S];
    bit          prev_lvl;
    bit          armed_m;
    bit          in_pulse;
    bit          hitor_m;
    int          len_m;
    logic [7:0]  toa_m;
    bit          pend_v;
    logic [11:0] pend_w;
    logic [11:0] q[$];
    int          ovf_m;

    rd53_pix_tot_digitizer dut (
        .CLK       (CLK),
        .RST       (RST),
        .HIT       (HIT),
        .MASK      (MASK),
        .BCID      (BCID),
        .HIT_OR    (HIT_OR),
        .TOT_DATA  (TOT_DATA),
        .TOA_DATA  (TOA_DATA),
        .TOT_VALID (TOT_VALID),
        .TOT_READY (TOT_READY),
        .OVF_CNT   (OVF_CNT),
        .BUSY      (BUSY)
    );

    always #12 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit lvl;
        if (RST) begin
            for (int i = 0; i < S; i++) begin
                smp[i]      = 1'b0;
                smp_real[i] = 1'b0;
            end
            prev_lvl = 1'b0;
            armed_m  = 1'b0;
            in_pulse = 1'b0;
            hitor_m  = 1'b0;
            pend_v   = 1'b0;
            len_m    = 0;
            q.delete();
            ovf_m = 0;
            return;
        end
        lvl = smp[S-1] & ~MASK;
        if (q.size() > 0 && TOT_READY)
            void'(q.pop_front());
        if (pend_v) begin
            if (q.size() < D)
                q.push_back(pend_w);
            else if (ovf_m < 255)
                ovf_m++;
        end
        pend_v = 1'b0;
        if (in_pulse) begin
            if (lvl) begin
                if (len_m < TMAX)
                    len_m++;
            end else begin
                pend_v   = 1'b1;
                pend_w   = {toa_m, 4'(len_m)};
                in_pulse = 1'b0;
            end
        end else if (lvl && !prev_lvl && armed_m) begin
            in_pulse = 1'b1;
            len_m    = 1;
            toa_m    = BCID;
        end
        if (smp_real[S-1] && !smp[S-1])
            armed_m = 1'b1;
        prev_lvl = lvl;
        hitor_m  = lvl;
        for (int i = S - 1; i > 0; i--) begin
            smp[i]      = smp[i-1];
            smp_real[i] = smp_real[i-1];
        end
        smp[0]      = HIT;
        smp_real[0] = 1'b1;
    endtask

    task automatic tick();
        logic [11:0] head;
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
        chk("valid", 32'(TOT_VALID), 32'(q.size() > 0));
        if (q.size() > 0) begin
            head = q[0];
            chk("tot", 32'(TOT_DATA), 32'(head[3:0]));
            chk("toa", 32'(TOA_DATA), 32'(head[11:4]));
        end
        chk("ovf", 32'(OVF_CNT), 32'(ovf_m));
        chk("busy", 32'(BUSY), 32'(in_pulse));
        chk("hit_or", 32'(HIT_OR), 32'(hitor_m));
    endtask

    task automatic wait_valid(input string tag, input int n);
        int i = 0;
        while (!TOT_VALID && i < n) begin
            tick();
            i++;
        end
        chk(tag, 32'(TOT_VALID), 32'd1);
    endtask

    initial begin
        bit seen;
        bit done;
        RST = 1'b1;
        HIT = 1'b1;
        MASK = 1'b0;
        TOT_READY = 1'b0;
        BCID = 8'h00;
        @(negedge CLK);
        repeat (3) tick();
        chk("rst_tot", 32'(TOT_DATA), 32'd0);
        chk("rst_toa", 32'(TOA_DATA), 32'd0);
        chk("rst_valid", 32'(TOT_VALID), 32'd0);

        // HIT high across reset release must not count
        RST = 1'b0;
        repeat (10) tick();
        chk("stuck_no_push", 32'(TOT_VALID), 32'd0);
        HIT = 1'b0;
        repeat (4) tick();
        HIT = 1'b1;
        repeat (3) tick();
        HIT = 1'b0;
        wait_valid("tot3_wait", 10);
        chk("tot3", 32'(TOT_DATA), 32'd3);
        TOT_READY = 1'b1;
        tick();

        // 5-cycle hit, TOA capture, single-cycle valid with ready high
        BCID = 8'h12;
        HIT = 1'b1;
        repeat (5) tick();
        HIT = 1'b0;
        wait_valid("tot5_wait", 10);
        chk("tot5", 32'(TOT_DATA), 32'd5);
        chk("toa12", 32'(TOA_DATA), 32'h12);
        tick();
        chk("tot5_one_cycle", 32'(TOT_VALID), 32'd0);

        // saturation
        TOT_READY = 1'b0;
        BCID = 8'h40;
        HIT = 1'b1;
        repeat (20) tick();
        chk("sat_busy", 32'(BUSY), 32'd1);
        repeat (20) tick();
        HIT = 1'b0;
        wait_valid("sat_wait", 10);
        chk("sat_tot", 32'(TOT_DATA), 32'd15);
        chk("sat_busy_low", 32'(BUSY), 32'd0);
        TOT_READY = 1'b1;
        tick();
        TOT_READY = 1'b0;
        tick();

        // three 2-cycle hits into a 2-entry buffer
        repeat (3) begin
            HIT = 1'b1;
            repeat (2) tick();
            HIT = 1'b0;
            tick();
            BCID++;
        end
        repeat (6) tick();
        chk("ovf1", 32'(OVF_CNT), 32'd1);
        chk("full_valid", 32'(TOT_VALID), 32'd1);
        chk("full_tot", 32'(TOT_DATA), 32'd2);
        repeat (3) tick();
        TOT_READY = 1'b1;
        chk("drain0_tot", 32'(TOT_DATA), 32'd2);
        tick();
        chk("drain1_valid", 32'(TOT_VALID), 32'd1);
        chk("drain1_tot", 32'(TOT_DATA), 32'd2);
        tick();
        chk("drain_empty", 32'(TOT_VALID), 32'd0);
        TOT_READY = 1'b0;

        // mask rising during a hit, then stuck-high masked pixel
        HIT = 1'b1;
        repeat (S + 3) tick();
        MASK = 1'b1;
        repeat (7) tick();
        wait_valid("mask_wait", 10);
        chk("mask_tot", 32'(TOT_DATA), 32'd3);
        repeat (20) tick();
        chk("mask_hit_or", 32'(HIT_OR), 32'd0);
        chk("mask_one_entry", 32'(TOT_VALID), 32'd1);
        TOT_READY = 1'b1;
        tick();
        TOT_READY = 1'b0;
        repeat (5) tick();
        chk("mask_no_more", 32'(TOT_VALID), 32'd0);
        HIT = 1'b0;
        MASK = 1'b0;
        repeat (4) tick();

        // full buffer with push and pop in the same cycle
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (4) tick();
        repeat (2) begin
            HIT = 1'b1;
            repeat (2) tick();
            HIT = 1'b0;
            tick();
        end
        repeat (4) tick();
        chk("fill_valid", 32'(TOT_VALID), 32'd1);
        HIT = 1'b1;
        repeat (2) tick();
        HIT = 1'b0;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (BUSY)
                seen = 1'b1;
            else if (seen)
                done = 1'b1;
        end
        chk("busy_fall_wait", 32'(done), 32'd1);
        TOT_READY = 1'b1;
        tick();
        TOT_READY = 1'b0;
        chk("pushpop_ovf", 32'(OVF_CNT), 32'd0);
        chk("pushpop_valid", 32'(TOT_VALID), 32'd1);
        TOT_READY = 1'b1;
        repeat (3) tick();
        TOT_READY = 1'b0;

        // random traffic against the model
        repeat (3000) begin
            if ($urandom_range(3) == 0)
                HIT = ~HIT;
            if ($urandom_range(39) == 0)
                MASK = ~MASK;
            TOT_READY = ($urandom_range(3) == 0);
            RST = ($urandom_range(499) == 0);
            BCID++;
            tick();
        end
        RST = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
